// File: rtl/clkgen_phased.sv
// clkgen_phased: N-channel phased clock generator running off refclk.
// Each channel divides refclk by a programmable integer and starts with a
// programmable phase offset. A lock sequencer holds all outputs low for
// LOCK_CYCLES edges, then releases every channel together so that the
// channels' relative phases are deterministic. A valid/ready config port
// changes one channel's divider/phase at runtime and triggers a relock.
// Optional feature macro: CLKGEN_PULSE_EN adds a per-channel outpulse port
// (one-cycle strobe coinciding with each outclk rising edge).
module clkgen_phased #(
  parameter int NUM_CLOCKS  = 3,
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 4,
  parameter int PHASE_STEP  = 1,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [CNT_W-1:0]      cfg_div,
  input  logic [CNT_W-1:0]      cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
`ifdef CLKGEN_PULSE_EN
  output logic [NUM_CLOCKS-1:0] outpulse,
`endif
  output logic                  locked
);

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  typedef enum logic {
    LOCKING = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  state_t             state;
  logic [LOCK_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]   div_r   [NUM_CLOCKS];
  logic [CNT_W-1:0]   phase_r [NUM_CLOCKS];
  logic [CNT_W-1:0]   cnt_r   [NUM_CLOCKS];

  logic cfg_fire;
  logic cfg_ok;

  // Reset phase of channel i is staggered by PHASE_STEP, folded into one period.
  function automatic logic [CNT_W-1:0] default_phase(input int i);
    return CNT_W'((i * PHASE_STEP) % DIV_DEFAULT);
  endfunction

  // Counter value that places the first rising edge p cycles after phase 0.
  function automatic logic [CNT_W-1:0] start_count(input logic [CNT_W-1:0] div,
                                                    input logic [CNT_W-1:0] ph);
    return (ph == '0) ? '0 : CNT_W'(div - ph);
  endfunction

  assign cfg_ready = (state == LOCKED);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_ok    = (cfg_div >= CNT_W'(2)) && (cfg_phase < cfg_div) &&
                     (int'(cfg_chan) < NUM_CLOCKS);

  // Lock sequencer, channel counters, config register file and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, matching the hardware that is inferred.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      state    <= LOCKING;
      lock_cnt <= '0;
      locked   <= 1'b0;
      cfg_err  <= 1'b0;
      outclk   <= '0;
`ifdef CLKGEN_PULSE_EN
      outpulse <= '0;
`endif
      // NOTE: the per-channel config arrays are a handful of flops, not a RAM,
      // so they are reset explicitly to their documented defaults.
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_r[i]   <= CNT_W'(DIV_DEFAULT);
        phase_r[i] <= default_phase(i);
        cnt_r[i]   <= '0;
      end
    end else begin
      cfg_err <= 1'b0;
      case (state)
        LOCKING: begin
          outclk <= '0;
`ifdef CLKGEN_PULSE_EN
          outpulse <= '0;
`endif
          if (lock_cnt == LOCK_LAST) begin
            state    <= LOCKED;
            locked   <= 1'b1;
            lock_cnt <= '0;
            // All channels restart together from their phase-adjusted counts.
            for (int i = 0; i < NUM_CLOCKS; i++)
              cnt_r[i] <= start_count(div_r[i], phase_r[i]);
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end

        LOCKED: begin
          if (cfg_fire && cfg_ok) begin
            // Accepted reconfig: update the one channel, then relock everything.
            state    <= LOCKING;
            locked   <= 1'b0;
            lock_cnt <= '0;
            outclk   <= '0;
`ifdef CLKGEN_PULSE_EN
            outpulse <= '0;
`endif
            for (int i = 0; i < NUM_CLOCKS; i++) begin
              if (cfg_chan == CH_W'(i)) begin
                div_r[i]   <= cfg_div;
                phase_r[i] <= cfg_phase;
              end
            end
          end else begin
            // Rejected requests only raise cfg_err; the outputs run on undisturbed.
            cfg_err <= cfg_fire;
            for (int i = 0; i < NUM_CLOCKS; i++) begin
              cnt_r[i]  <= (cnt_r[i] == CNT_W'(div_r[i] - 1'b1)) ? '0 : cnt_r[i] + 1'b1;
              outclk[i] <= (cnt_r[i] < (div_r[i] >> 1));
`ifdef CLKGEN_PULSE_EN
              outpulse[i] <= (cnt_r[i] == '0);
`endif
            end
          end
        end

        default: begin
          state <= LOCKING;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkgen_phased.sv
// Self-checking bench for clkgen_phased with default parameters
// (3 channels, DIV 4, phase step 1, LOCK 16). Outputs are sampled 1 ns
// after each rising edge; inputs are driven at the same point.
module tb_clkgen_phased;

  localparam int NC    = 3;
  localparam int CW    = 8;
  localparam int LOCK  = 16;
  localparam int CHW   = 2;

  logic            refclk = 1'b0;
  logic            rst;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [CHW-1:0]  cfg_chan;
  logic [CW-1:0]   cfg_div;
  logic [CW-1:0]   cfg_phase;
  logic            cfg_err;
  logic [NC-1:0]   outclk;
  logic            locked;
`ifdef CLKGEN_PULSE_EN
  logic [NC-1:0]   outpulse;
`endif

  int n_checks = 0;
  int n_errors = 0;

  clkgen_phased #(
    .NUM_CLOCKS (NC),
    .CNT_W      (CW),
    .DIV_DEFAULT(4),
    .PHASE_STEP (1),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .cfg_err  (cfg_err),
    .outclk   (outclk),
`ifdef CLKGEN_PULSE_EN
    .outpulse (outpulse),
`endif
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    string          name;
    logic           valid;
    logic [CHW-1:0] chan;
    logic [CW-1:0]  div;
    logic [CW-1:0]  phase;
    logic [NC-1:0]  exp_clk;
    logic           exp_locked;
    logic           exp_err;
    logic           exp_ready;
  } vec_t;

  function automatic vec_t mk(string name, logic valid, logic [CHW-1:0] chan,
                              logic [CW-1:0] div, logic [CW-1:0] phase,
                              logic [NC-1:0] exp_clk, logic exp_locked,
                              logic exp_err, logic exp_ready);
    vec_t v;
    v.name = name; v.valid = valid; v.chan = chan; v.div = div; v.phase = phase;
    v.exp_clk = exp_clk; v.exp_locked = exp_locked; v.exp_err = exp_err;
    v.exp_ready = exp_ready;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic idle_cfg();
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_phase = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    cfg_valid = v.valid;
    cfg_chan  = v.chan;
    cfg_div   = v.div;
    cfg_phase = v.phase;
    tick();
    check({v.name, ".outclk"}, 32'(outclk), 32'(v.exp_clk));
    check({v.name, ".locked"}, 32'(locked), 32'(v.exp_locked));
    check({v.name, ".cfg_err"}, 32'(cfg_err), 32'(v.exp_err));
    check({v.name, ".cfg_ready"}, 32'(cfg_ready), 32'(v.exp_ready));
  endtask

  // Edges first_k..LOCK after a reset release or accepted config: outputs stay
  // low, locked rises exactly on edge LOCK.
  task automatic relock_check(input string name, input int first_k);
    for (int k = first_k; k <= LOCK; k++) begin
      tick();
      check($sformatf("%s.locked@%0d", name, k), 32'(locked), 32'(k == LOCK));
      check($sformatf("%s.ready@%0d", name, k), 32'(cfg_ready), 32'(k == LOCK));
      check($sformatf("%s.outclk@%0d", name, k), 32'(outclk), 32'(0));
`ifdef CLKGEN_PULSE_EN
      check($sformatf("%s.outpulse@%0d", name, k), 32'(outpulse), 32'(0));
`endif
    end
  endtask

  // Default-configuration pattern {ch2,ch1,ch0} right after lock.
  task automatic default_pattern(input string name);
    logic [NC-1:0] pat [4];
    pat[0] = 3'b001; pat[1] = 3'b011; pat[2] = 3'b110; pat[3] = 3'b100;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("%s.outclk[%0d]", name, k), 32'(outclk), 32'(pat[k % 4]));
    end
  endtask

  task automatic accept(input string name, input logic [CHW-1:0] chan,
                        input logic [CW-1:0] div, input logic [CW-1:0] phase);
    cfg_valid = 1'b1; cfg_chan = chan; cfg_div = div; cfg_phase = phase;
    tick();
    idle_cfg();
    check({name, ".locked_low"}, 32'(locked), 32'(0));
    check({name, ".outclk_low"}, 32'(outclk), 32'(0));
  endtask

  vec_t steady [12];
  vec_t relock [11];

  initial begin
    // Default channels: cnt at lock = {2,3,0}; patterns repeat every 4.
    steady[0]  = mk("st0",  0, 0, 0, 0, 3'b001, 1, 0, 1);
    steady[1]  = mk("st1",  0, 0, 0, 0, 3'b011, 1, 0, 1);
    steady[2]  = mk("bad_div1", 1, 0, 1, 0, 3'b110, 1, 1, 1);
    steady[3]  = mk("st3",  0, 0, 0, 0, 3'b100, 1, 0, 1);
    steady[4]  = mk("bad_phase", 1, 0, 6, 6, 3'b001, 1, 1, 1);
    steady[5]  = mk("bad_chan", 1, 3, 5, 0, 3'b011, 1, 1, 1);
    steady[6]  = mk("st6",  0, 0, 0, 0, 3'b110, 1, 0, 1);
    steady[7]  = mk("st7",  0, 0, 0, 0, 3'b100, 1, 0, 1);
    steady[8]  = mk("st8",  0, 0, 0, 0, 3'b001, 1, 0, 1);
    steady[9]  = mk("cfg_ch1_div5", 1, 1, 5, 0, 3'b000, 0, 0, 0);
    steady[10] = mk("locking_bad", 1, 0, 1, 0, 3'b000, 0, 0, 0);
    steady[11] = mk("locking_ignored", 1, 0, 7, 3, 3'b000, 0, 0, 0);

    // After relock: ch0 div4 ph0, ch1 div5 ph0, ch2 div4 ph2.
    relock[0]  = mk("rl0",  0, 0, 0, 0, 3'b011, 1, 0, 1);
    relock[1]  = mk("rl1",  0, 0, 0, 0, 3'b011, 1, 0, 1);
    relock[2]  = mk("rl2",  0, 0, 0, 0, 3'b100, 1, 0, 1);
    relock[3]  = mk("rl3",  0, 0, 0, 0, 3'b100, 1, 0, 1);
    relock[4]  = mk("rl4",  0, 0, 0, 0, 3'b001, 1, 0, 1);
    relock[5]  = mk("rl5",  0, 0, 0, 0, 3'b011, 1, 0, 1);
    relock[6]  = mk("rl6",  0, 0, 0, 0, 3'b110, 1, 0, 1);
    relock[7]  = mk("rl7",  0, 0, 0, 0, 3'b100, 1, 0, 1);
    relock[8]  = mk("rl8",  0, 0, 0, 0, 3'b001, 1, 0, 1);
    relock[9]  = mk("rl9",  0, 0, 0, 0, 3'b001, 1, 0, 1);
    relock[10] = mk("rl10", 0, 0, 0, 0, 3'b110, 1, 0, 1);

    rst = 1'b0;
    idle_cfg();
    tick();
    tick();
    check("reset.outclk", 32'(outclk), 32'(0));
    check("reset.locked", 32'(locked), 32'(0));
    check("reset.cfg_ready", 32'(cfg_ready), 32'(0));
    check("reset.cfg_err", 32'(cfg_err), 32'(0));

    rst = 1'b1;
    relock_check("initial_lock", 1);

    for (int i = 0; i < 12; i++) apply_vec(steady[i]);
    idle_cfg();
    relock_check("relock_ch1", 3);
    for (int i = 0; i < 11; i++) apply_vec(relock[i]);

    // ch2 div3 phase2: 1 high / 2 low, first rise two cycles late.
    begin
      logic [NC-1:0] exp_clk [6];
      logic [NC-1:0] exp_p2;
      exp_clk[0] = 3'b011; exp_clk[1] = 3'b011; exp_clk[2] = 3'b100;
      exp_clk[3] = 3'b000; exp_clk[4] = 3'b001; exp_clk[5] = 3'b111;
      exp_p2 = 3'b100;
      accept("cfg_ch2_div3", 2, 3, 2);
      relock_check("relock_ch2", 1);
      for (int k = 0; k < 6; k++) begin
        tick();
        check($sformatf("div3.outclk[%0d]", k), 32'(outclk), 32'(exp_clk[k]));
`ifdef CLKGEN_PULSE_EN
        check($sformatf("div3.outpulse2[%0d]", k), 32'(outpulse[2]),
              32'(exp_p2[k % 3]));
`endif
      end
    end

    // ch1 div2 phase1: toggle starting low; others re-phased.
    begin
      logic [NC-1:0] exp_clk [4];
      exp_clk[0] = 3'b001; exp_clk[1] = 3'b011; exp_clk[2] = 3'b100; exp_clk[3] = 3'b010;
      accept("cfg_ch1_div2", 1, 2, 1);
      relock_check("relock_div2", 1);
      for (int k = 0; k < 4; k++) begin
        tick();
        check($sformatf("div2.outclk[%0d]", k), 32'(outclk), 32'(exp_clk[k]));
      end
    end

    // Reset mid-LOCKED with a valid request present: reset wins, defaults return.
    rst = 1'b0;
    cfg_valid = 1'b1; cfg_chan = 0; cfg_div = 7; cfg_phase = 3;
    tick();
    idle_cfg();
    check("rst_locked.outclk", 32'(outclk), 32'(0));
    check("rst_locked.locked", 32'(locked), 32'(0));
    check("rst_locked.cfg_ready", 32'(cfg_ready), 32'(0));
    check("rst_locked.cfg_err", 32'(cfg_err), 32'(0));
    rst = 1'b1;
    relock_check("rst_locked_relock", 1);
    default_pattern("rst_locked_dflt");

    // Reset in the middle of a relock after an accepted config.
    accept("cfg_ch0_div7", 0, 7, 3);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b0;
    tick();
    check("rst_relock.outclk", 32'(outclk), 32'(0));
    check("rst_relock.locked", 32'(locked), 32'(0));
    check("rst_relock.cfg_ready", 32'(cfg_ready), 32'(0));
    rst = 1'b1;
    relock_check("rst_relock_relock", 1);
    default_pattern("rst_relock_dflt");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
